// File: rtl/date_pkg.sv
// -----------------------------------------------------------------------------
// date_pkg
// Shared definitions for the calendar date path: field widths, the edit
// sequencer state encoding, the edit_field display encoding and the calendar
// helper functions (leap year, month length). The date block uses the same
// functions, so both sides agree on which dates are legal.
// -----------------------------------------------------------------------------
package date_pkg;

   localparam int YEAR_W  = 14;
   localparam int MONTH_W = 4;
   localparam int DAY_W   = 5;
   localparam int DATE_W  = 23;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_EDIT_YEAR  = 3'd1,
      ST_EDIT_MONTH = 3'd2,
      ST_EDIT_DAY   = 3'd3,
      ST_COMMIT     = 3'd4
   } state_t;

   localparam logic [1:0] FIELD_NONE  = 2'd0;
   localparam logic [1:0] FIELD_YEAR  = 2'd1;
   localparam logic [1:0] FIELD_MONTH = 2'd2;
   localparam logic [1:0] FIELD_DAY   = 2'd3;

   // Gregorian leap-year rule.
   function automatic logic is_leap(input logic [YEAR_W-1:0] year);
      return (((year % 14'd4) == 14'd0) && ((year % 14'd100) != 14'd0)) ||
             ((year % 14'd400) == 14'd0);
   endfunction

   // Length of the given month; returns 0 for an out-of-range month so that
   // any day value compares as illegal against it.
   function automatic logic [DAY_W-1:0] days_in_month(input logic [YEAR_W-1:0]  year,
                                                      input logic [MONTH_W-1:0] month);
      logic [DAY_W-1:0] dim;
      case (month)
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: dim = 5'd31;
         4'd4, 4'd6, 4'd9, 4'd11:                    dim = 5'd30;
         4'd2:                                       dim = is_leap(year) ? 5'd29 : 5'd28;
         default:                                    dim = 5'd0;
      endcase
      return dim;
   endfunction

endpackage

// File: rtl/date_field_step.sv
// -----------------------------------------------------------------------------
// date_field_step
// Combinational up/down step for one date field with wrap-around.
//   val_i   : current field value
//   min_i   : lowest legal value (up from max wraps here)
//   max_i   : highest legal value (down from min wraps here)
//   up_i    : request increment
//   down_i  : request decrement
//   val_o   : stepped value; unchanged when neither or both requests are set
// -----------------------------------------------------------------------------
module date_field_step #(
   parameter int W = 8
) (
   input  logic [W-1:0] val_i,
   input  logic [W-1:0] min_i,
   input  logic [W-1:0] max_i,
   input  logic         up_i,
   input  logic         down_i,
   output logic [W-1:0] val_o
);

   always_comb begin
      val_o = val_i;
      if (up_i && !down_i) begin
         val_o = (val_i >= max_i) ? min_i : val_i + W'(1);
      end else if (down_i && !up_i) begin
         val_o = (val_i <= min_i) ? max_i : val_i - W'(1);
      end
   end

endmodule

// File: rtl/date_set_ctrl.sv
// -----------------------------------------------------------------------------
// date_set_ctrl
// User-edit sequencer for the calendar date register. Captures the live date
// on btn_mode, walks the user through year -> month -> day with up/down
// buttons (always keeping the shadow date legal), then issues a one-cycle
// load strobe to the date block.
//
// Ports
//   clk, rst      : clock, synchronous active-low reset
//   tick          : slow time base pulse (blink and edit timeout)
//   btn_mode      : enter edit / advance field / commit after day
//   btn_up/down   : step current field (both together = ignored)
//   btn_cancel    : abandon edit without loading
//   cur_date      : live {year, month, day} from the date block
//   set_date      : one-cycle load strobe
//   bin_date      : shadow {year, month, day}; qualified by set_date
//   editing       : high in any edit state
//   edit_field    : 0 none, 1 year, 2 month, 3 day
//   blink         : display blank phase
//   dbg_state     : current sequencer state, for observation only
//
// Button/load semantics: buttons are single-cycle pulses acted on in the cycle
// they are high (cancel > mode > up/down); set_date is a single-cycle strobe
// with no back-pressure and bin_date is only meaningful while it is high.
// -----------------------------------------------------------------------------
module date_set_ctrl
   import date_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 30,
   parameter int YEAR_MIN      = 1,
   parameter int YEAR_MAX      = 9999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              btn_mode,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_cancel,
   input  logic [DATE_W-1:0] cur_date,
   output logic              set_date,
   output logic [DATE_W-1:0] bin_date,
   output logic              editing,
   output logic [1:0]        edit_field,
   output logic              blink,
   output state_t            dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

   state_t               state_q, state_d;
   logic [YEAR_W-1:0]    year_q,  year_d;
   logic [MONTH_W-1:0]   month_q, month_d;
   logic [DAY_W-1:0]     day_q,   day_d;
   logic [CNT_W-1:0]     cnt_q,   cnt_d;
   logic                 blink_q, blink_d;

   // Live date fields and capture validation
   logic [YEAR_W-1:0]    cap_year;
   logic [MONTH_W-1:0]   cap_month;
   logic [DAY_W-1:0]     cap_day;
   logic                 cap_ok;

   assign cap_year  = cur_date[DATE_W-1 -: YEAR_W];
   assign cap_month = cur_date[DAY_W +: MONTH_W];
   assign cap_day   = cur_date[DAY_W-1:0];
   assign cap_ok    = (cap_month >= 4'd1) && (cap_month <= 4'd12) &&
                      (cap_day >= 5'd1) && (cap_day <= days_in_month(cap_year, cap_month));

   logic any_btn, press, edit_q, edit_d, timeout_hit;
   logic [YEAR_W-1:0]  year_step;
   logic [MONTH_W-1:0] month_step;
   logic [DAY_W-1:0]   day_step;
   logic [DAY_W-1:0]   dim_cur, dim_new_year, dim_new_month;

   assign any_btn     = btn_mode | btn_up | btn_down | btn_cancel;
   assign press       = btn_up | btn_down;
   assign edit_q      = (state_q == ST_EDIT_YEAR) || (state_q == ST_EDIT_MONTH) ||
                        (state_q == ST_EDIT_DAY);
   assign edit_d      = (state_d == ST_EDIT_YEAR) || (state_d == ST_EDIT_MONTH) ||
                        (state_d == ST_EDIT_DAY);
   // The tick that would bring the idle count to TIMEOUT_TICKS ends the
   // session; any button in that same cycle takes precedence.
   assign timeout_hit = tick && !any_btn && (cnt_q == CNT_W'(TIMEOUT_TICKS - 1));

   assign dim_cur       = days_in_month(year_q, month_q);
   assign dim_new_year  = days_in_month(year_step, month_q);
   assign dim_new_month = days_in_month(year_q, month_step);

   date_field_step #(.W(YEAR_W)) u_year_step (
      .val_i  (year_q),
      .min_i  (YEAR_W'(YEAR_MIN)),
      .max_i  (YEAR_W'(YEAR_MAX)),
      .up_i   (btn_up),
      .down_i (btn_down),
      .val_o  (year_step)
   );

   date_field_step #(.W(MONTH_W)) u_month_step (
      .val_i  (month_q),
      .min_i  (4'd1),
      .max_i  (4'd12),
      .up_i   (btn_up),
      .down_i (btn_down),
      .val_o  (month_step)
   );

   date_field_step #(.W(DAY_W)) u_day_step (
      .val_i  (day_q),
      .min_i  (5'd1),
      .max_i  (dim_cur),
      .up_i   (btn_up),
      .down_i (btn_down),
      .val_o  (day_step)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Shadow date, timeout counter and blink phase
   always_ff @(posedge clk) begin
      if (!rst) begin
         year_q  <= '0;
         month_q <= '0;
         day_q   <= '0;
         cnt_q   <= '0;
         blink_q <= 1'b0;
      end else begin
         year_q  <= year_d;
         month_q <= month_d;
         day_q   <= day_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
      end
   end

   // Next-state and shadow update
   always_comb begin
      state_d = state_q;
      year_d  = year_q;
      month_d = month_q;
      day_d   = day_q;

      case (state_q)
         ST_IDLE: begin
            if (btn_mode) begin
               state_d = ST_EDIT_YEAR;
               if (cap_ok) begin
                  year_d  = cap_year;
                  month_d = cap_month;
                  day_d   = cap_day;
               end else begin
                  year_d  = YEAR_W'(YEAR_MIN);
                  month_d = 4'd1;
                  day_d   = 5'd1;
               end
            end
         end
         ST_EDIT_YEAR, ST_EDIT_MONTH, ST_EDIT_DAY: begin
            if (btn_cancel || timeout_hit) begin
               state_d = ST_IDLE;
            end else if (btn_mode) begin
               case (state_q)
                  ST_EDIT_YEAR:  state_d = ST_EDIT_MONTH;
                  ST_EDIT_MONTH: state_d = ST_EDIT_DAY;
                  default:       state_d = ST_COMMIT;
               endcase
            end else if (press) begin
               // Year/month changes clamp the day to the new month length
               // in the same update so the shadow never holds an illegal date.
               case (state_q)
                  ST_EDIT_YEAR: begin
                     year_d = year_step;
                     day_d  = (day_q > dim_new_year) ? dim_new_year : day_q;
                  end
                  ST_EDIT_MONTH: begin
                     month_d = month_step;
                     day_d   = (day_q > dim_new_month) ? dim_new_month : day_q;
                  end
                  default: begin
                     day_d = day_step;
                  end
               endcase
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Idle-time counter: cleared outside a session and on any button.
      cnt_d = cnt_q;
      if (!edit_q || !edit_d || any_btn) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Blink phase: a step press forces the visible phase.
      blink_d = blink_q;
      if (!edit_q || !edit_d || press) begin
         blink_d = 1'b0;
      end else if (tick) begin
         blink_d = ~blink_q;
      end
   end

   // Outputs
   always_comb begin
      set_date  = (state_q == ST_COMMIT);
      bin_date  = {year_q, month_q, day_q};
      editing   = edit_q;
      dbg_state = state_q;
      case (state_q)
         ST_EDIT_YEAR:  edit_field = FIELD_YEAR;
         ST_EDIT_MONTH: edit_field = FIELD_MONTH;
         ST_EDIT_DAY:   edit_field = FIELD_DAY;
         default:       edit_field = FIELD_NONE;
      endcase
      // Show the value in the very cycle of a press, not one cycle later.
      blink = blink_q & ~press;
   end

endmodule

// File: tb/tb_date_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_date_set_ctrl
// Directed bench for date_set_ctrl with a short edit timeout (3 ticks).
// -----------------------------------------------------------------------------
module tb_date_set_ctrl;
   import date_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              tick = 1'b0;
   logic              btn_mode = 1'b0;
   logic              btn_up = 1'b0;
   logic              btn_down = 1'b0;
   logic              btn_cancel = 1'b0;
   logic [DATE_W-1:0] cur_date = '0;
   logic              set_date;
   logic [DATE_W-1:0] bin_date;
   logic              editing;
   logic [1:0]        edit_field;
   logic              blink;
   state_t            dbg_state;

   int checks   = 0;
   int failures = 0;
   int load_cnt = 0;

   // Clock / reset block
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog run did not finish");
      $fatal(1, "watchdog");
   end

   date_set_ctrl #(
      .TIMEOUT_TICKS (3),
      .YEAR_MIN      (1),
      .YEAR_MAX      (9999)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .btn_mode   (btn_mode),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_cancel (btn_cancel),
      .cur_date   (cur_date),
      .set_date   (set_date),
      .bin_date   (bin_date),
      .editing    (editing),
      .edit_field (edit_field),
      .blink      (blink),
      .dbg_state  (dbg_state)
   );

   // Count every clock cycle that carries a load strobe.
   always @(negedge clk) begin
      if (set_date) load_cnt++;
   end

   function automatic logic [DATE_W-1:0] mk(input int y, input int m, input int d);
      return {14'(y), 4'(m), 5'(d)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver tasks: inputs change 1 ns after a rising edge, outputs are
   // sampled at the same point.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic m, input logic u, input logic d,
                        input logic c, input logic t);
      btn_mode = m; btn_up = u; btn_down = d; btn_cancel = c; tick = t;
      #1;
      if (u || d) chk("blink_press", 32'(blink), 32'd0);
      @(posedge clk);
      #1;
      btn_mode = 0; btn_up = 0; btn_down = 0; btn_cancel = 0; tick = 0;
   endtask

   task automatic mode();   pulse(1, 0, 0, 0, 0); endtask
   task automatic up();     pulse(0, 1, 0, 0, 0); endtask
   task automatic down();   pulse(0, 0, 1, 0, 0); endtask
   task automatic cancel(); pulse(0, 0, 0, 1, 0); endtask
   task automatic tk();     pulse(0, 0, 0, 0, 1); endtask

   initial begin
      // Reset
      rst = 1'b0;
      repeat (3) cycle();
      chk("rst_set_date", 32'(set_date), 32'd0);
      chk("rst_bin_date", 32'(bin_date), 32'd0);
      chk("rst_editing", 32'(editing), 32'd0);
      chk("rst_field", 32'(edit_field), 32'd0);
      chk("rst_blink", 32'(blink), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b1;
      cycle();

      // Non-mode button in IDLE is ignored
      up();
      chk("idle_up_ignored", 32'(editing), 32'd0);

      // Commit with leap-day clamp
      cur_date = mk(2024, 2, 29);
      mode();
      chk("t1_editing", 32'(editing), 32'd1);
      chk("t1_field_year", 32'(edit_field), 32'd1);
      chk("t1_capture", 32'(bin_date), 32'(mk(2024, 2, 29)));
      tk();
      chk("t1_blink_on", 32'(blink), 32'd1);
      up();
      chk("t1_year_clamp", 32'(bin_date), 32'(mk(2025, 2, 28)));
      chk("t1_blink_after_up", 32'(blink), 32'd0);
      mode();
      chk("t1_field_month", 32'(edit_field), 32'd2);
      mode();
      chk("t1_field_day", 32'(edit_field), 32'd3);
      chk("t1_no_load_yet", 32'(set_date), 32'd0);
      mode();
      chk("t1_set_date", 32'(set_date), 32'd1);
      chk("t1_bin_date", 32'(bin_date), 32'(mk(2025, 2, 28)));
      chk("t1_state_commit", 32'(dbg_state), 32'(ST_COMMIT));
      cycle();
      chk("t1_set_date_drop", 32'(set_date), 32'd0);
      chk("t1_back_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("t1_load_once", 32'(load_cnt), 32'd1);

      // Year and month wrap
      cur_date = mk(9999, 12, 31);
      mode();
      up();
      chk("t2_year_wrap", 32'(bin_date), 32'(mk(1, 12, 31)));
      mode();
      up();
      chk("t2_month_wrap", 32'(bin_date), 32'(mk(1, 1, 31)));
      mode();
      mode();
      chk("t2_set_date", 32'(set_date), 32'd1);
      chk("t2_bin_date", 32'(bin_date), 32'(mk(1, 1, 31)));
      cycle();
      chk("t2_load_count", 32'(load_cnt), 32'd2);

      // Year down wrap from YEAR_MIN
      cur_date = mk(1, 3, 31);
      mode();
      down();
      chk("t2_year_down_wrap", 32'(bin_date), 32'(mk(9999, 3, 31)));
      cancel();

      // Day wrap and leap checks
      cur_date = mk(2023, 4, 30);
      mode(); mode(); mode();
      up();
      chk("t3_day_up_wrap", 32'(bin_date), 32'(mk(2023, 4, 1)));
      down();
      chk("t3_day_down_wrap", 32'(bin_date), 32'(mk(2023, 4, 30)));
      cancel();
      cur_date = mk(1900, 2, 1);
      mode(); mode(); mode();
      down();
      chk("t3_1900_feb", 32'(bin_date), 32'(mk(1900, 2, 28)));
      cancel();
      cur_date = mk(2000, 2, 1);
      mode(); mode(); mode();
      down();
      chk("t3_2000_feb", 32'(bin_date), 32'(mk(2000, 2, 29)));
      cancel();
      chk("t3_cancel_idle", 32'(editing), 32'd0);

      // Month change clamps day: 2023-01-31, month up -> Feb 28
      cur_date = mk(2023, 1, 31);
      mode(); mode();
      up();
      chk("t3_month_clamp", 32'(bin_date), 32'(mk(2023, 2, 28)));

      // Cancel in EDIT_MONTH
      cancel();
      chk("t4_cancel_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("t4_cancel_field", 32'(edit_field), 32'd0);

      // Timeout with no buttons in EDIT_DAY
      cur_date = mk(2022, 6, 15);
      mode(); mode(); mode();
      tk();
      chk("t4_blink_tick1", 32'(blink), 32'd1);
      tk();
      chk("t4_blink_tick2", 32'(blink), 32'd0);
      chk("t4_still_edit", 32'(editing), 32'd1);
      tk();
      chk("t4_timeout_idle", 32'(dbg_state), 32'(ST_IDLE));
      chk("t4_timeout_blink", 32'(blink), 32'd0);
      cycle();
      chk("t4_no_load", 32'(load_cnt), 32'd2);

      // Button on the third tick keeps the session alive
      mode(); mode(); mode();
      tk(); tk();
      pulse(0, 1, 0, 0, 1);
      chk("t4_btn_wins", 32'(editing), 32'd1);
      chk("t4_btn_step", 32'(bin_date), 32'(mk(2022, 6, 16)));
      chk("t4_btn_blink", 32'(blink), 32'd0);
      tk(); tk();
      chk("t4_counter_cleared", 32'(editing), 32'd1);
      tk();
      chk("t4_timeout2_idle", 32'(editing), 32'd0);

      // Reset mid-edit
      mode(); mode(); mode();
      tk();
      chk("t5_pre_rst_blink", 32'(blink), 32'd1);
      rst = 1'b0;
      cycle();
      chk("t5_rst_set_date", 32'(set_date), 32'd0);
      chk("t5_rst_bin_date", 32'(bin_date), 32'd0);
      chk("t5_rst_editing", 32'(editing), 32'd0);
      chk("t5_rst_field", 32'(edit_field), 32'd0);
      chk("t5_rst_blink", 32'(blink), 32'd0);
      chk("t5_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b1;
      cycle();
      chk("t5_no_load", 32'(load_cnt), 32'd2);

      // Invalid capture
      cur_date = mk(2021, 0, 5);
      mode();
      chk("t5_bad_month", 32'(bin_date), 32'(mk(1, 1, 1)));
      cancel();
      cur_date = mk(2023, 2, 29);
      mode();
      chk("t5_bad_day", 32'(bin_date), 32'(mk(1, 1, 1)));
      cancel();

      // Simultaneous buttons
      cur_date = mk(2010, 5, 10);
      mode();
      tk();
      chk("t6_blink_on", 32'(blink), 32'd1);
      pulse(0, 1, 1, 0, 0);
      chk("t6_updown_nochange", 32'(bin_date), 32'(mk(2010, 5, 10)));
      chk("t6_updown_field", 32'(edit_field), 32'd1);
      pulse(1, 1, 0, 0, 0);
      chk("t6_mode_up_field", 32'(edit_field), 32'd2);
      chk("t6_mode_up_value", 32'(bin_date), 32'(mk(2010, 5, 10)));
      up();
      chk("t6_month_up", 32'(bin_date), 32'(mk(2010, 6, 10)));
      pulse(1, 0, 0, 1, 0);
      chk("t6_cancel_beats_mode", 32'(dbg_state), 32'(ST_IDLE));
      cycle();
      chk("t6_final_loads", 32'(load_cnt), 32'd2);

      // Final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
